// File: rtl/mem_block_xfer.sv
// Block-transfer initiator: moves one aligned block of 16-bit words between a
// requester and a single-cycle memory, one word access per cycle.
module mem_block_xfer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // req_valid/req_ready: a request transfers on a rising edge where both are
  // high; req_ready is high only in IDLE and never depends on req_valid.
  input  logic                           req_valid,
  input  logic                           req_wr,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           req_ready,
  output logic [$clog2(BLOCK_WORDS)-1:0] wr_word_idx,
  input  logic [15:0]                    wr_word,
  output logic                           fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic [15:0]                    fill_data,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    {{(ADDR_WIDTH-IDX_W-1){1'b0}}, {(IDX_W+1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        beat_q, beat_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    fill_we_q, fill_we_d;
  logic [15:0]             fill_data_q, fill_data_d;
  logic [IDX_W-1:0]        fill_idx_q, fill_idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      op_wr_q     <= 1'b0;
      base_q      <= '0;
      fill_we_q   <= 1'b0;
      fill_data_q <= '0;
      fill_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      op_wr_q     <= op_wr_d;
      base_q      <= base_d;
      fill_we_q   <= fill_we_d;
      fill_data_q <= fill_data_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    op_wr_d     = op_wr_q;
    base_d      = base_q;
    fill_we_d   = 1'b0;
    fill_data_d = fill_data_q;
    fill_idx_d  = fill_idx_q;
    req_ready   = 1'b0;
    done        = 1'b0;
    wr_word_idx = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_wr_d = req_wr;
          base_d  = req_addr & ~OFF_MASK;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // OR rather than add: base is block aligned, so no carry can leave the block.
        mem_enable  = 1'b1;
        mem_wr      = op_wr_q;
        mem_addr    = base_q | ({{(ADDR_WIDTH-IDX_W){1'b0}}, beat_q} << 1);
        wr_word_idx = beat_q;
        if (op_wr_q) begin
          mem_data_in = wr_word;
        end else begin
          fill_we_d   = 1'b1;
          fill_data_d = mem_data_out;
          fill_idx_d  = beat_q;
        end
        beat_d = beat_q + IDX_W'(1);
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_we       = fill_we_q;
  assign fill_data     = fill_data_q;
  assign fill_word_idx = fill_idx_q;

endmodule

// File: tb/tb_mem_block_xfer.sv
// Randomized scoreboard bench for mem_block_xfer: a reference memory predicts
// every memory beat, fill word and done pulse, each tagged with its cycle.
module tb_mem_block_xfer;

  localparam int AW = 16;
  localparam int BW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_wr, req_ready;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] wr_word_idx, fill_word_idx;
  logic [15:0]   wr_word, fill_data, mem_data_in, mem_data_out;
  logic          fill_we, done, mem_enable, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   wr_base;

  always #5 clk = ~clk;

  // Requester write source: word k of a write block is wr_base ^ k.
  assign wr_word = wr_base ^ {{(16-IW){1'b0}}, wr_word_idx};

  mem_block_xfer #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_ready(req_ready),
    .wr_word_idx(wr_word_idx), .wr_word(wr_word),
    .fill_we(fill_we), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
    .done(done),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // ---------------- clock-cycle counter and attached memory ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int idx);
    if (idx >= 'h24 && idx < 'h2C) return 16'hA000 + 16'(idx - 'h24);
    return 16'(idx * 40503) ^ 16'h3C5A;
  endfunction

  logic [15:0] mem_arr [0:32767];
  bit          mem_init_done;
  assign mem_data_out = mem_arr[mem_addr[15:1]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32768; i++) mem_arr[i] = init_word(i);
      mem_init_done = 1'b1;
    end else if (mem_enable === 1'b1 && mem_wr === 1'b1) begin
      mem_arr[mem_addr[15:1]] = mem_data_in;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [15:0] ref_mem [0:32767];

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;
  typedef struct packed {
    logic [31:0]   cyc;
    logic [IW-1:0] idx;
    logic [15:0]   data;
  } fill_t;

  beat_t       exp_beat_q[$];
  fill_t       exp_fill_q[$];
  logic [31:0] exp_done_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_expected = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value 0x%0h (cycle %0d)", nm, act, cyc);
  endtask

  beat_t mb;
  fill_t mf;
  logic [31:0] md;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_without_enable", 32'(mem_wr === 1'b1 && mem_enable !== 1'b1), 32'd0);
      if (mem_enable === 1'b1) begin
        if (exp_beat_q.size() == 0) flag("beat", 32'(mem_addr));
        else begin
          mb = exp_beat_q.pop_front();
          chk("beat_cycle", cyc, mb.cyc);
          chk("beat_addr", 32'(mem_addr), 32'(mb.addr));
          chk("beat_wr", 32'(mem_wr), 32'(mb.wr));
          chk("beat_data_in", 32'(mem_data_in), 32'(mb.data));
        end
      end
      if (fill_we === 1'b1) begin
        if (exp_fill_q.size() == 0) flag("fill", 32'(fill_data));
        else begin
          mf = exp_fill_q.pop_front();
          chk("fill_cycle", cyc, mf.cyc);
          chk("fill_idx", 32'(fill_word_idx), 32'(mf.idx));
          chk("fill_data", 32'(fill_data), 32'(mf.data));
        end
      end
      if (done === 1'b1) begin
        done_seen++;
        if (exp_done_q.size() == 0) flag("done", 32'(cyc));
        else begin
          md = exp_done_q.pop_front();
          chk("done_cycle", cyc, md);
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wbase,
                       input int n_exp, output int acc);
    int          budget;
    logic [15:0] base;
    beat_t       b;
    fill_t       f;
    budget    = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    while (req_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (req_ready !== 1'b1) begin
      flag("accept_timeout", 32'(addr));
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc     = cyc;
    wr_base = wbase;
    base    = addr & ~16'(2 * BW - 1);
    for (int k = 0; k < n_exp; k++) begin
      b.cyc  = 32'(acc + 1 + k);
      b.wr   = wr;
      b.addr = base + 16'(2 * k);
      b.data = wr ? (wbase ^ 16'(k)) : 16'h0000;
      exp_beat_q.push_back(b);
      if (wr) begin
        ref_mem[int'(base >> 1) + k] = wbase ^ 16'(k);
      end else begin
        f.cyc  = 32'(acc + 2 + k);
        f.idx  = IW'(k);
        f.data = ref_mem[int'(base >> 1) + k];
        exp_fill_q.push_back(f);
      end
    end
    if (n_exp == BW) begin
      exp_done_q.push_back(32'(acc + BW + 1));
      done_expected++;
    end
    @(negedge clk);
    req_addr = 16'($urandom);
    req_wr   = 1'($urandom);
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_beat_q.size() + exp_fill_q.size() + exp_done_q.size()) != 0 && b < 40) begin
      @(negedge clk);
      b++;
    end
    chk("drain_pending", 32'(exp_beat_q.size() + exp_fill_q.size() + exp_done_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int a1, a2, prev_acc;
  logic rw;
  logic [15:0] ra;
  bit chain;

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 16'h0040;
    wr_base   = 16'h0000;

    // Reset held for two edges with a pending request.
    @(negedge clk);
    mon_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_fill_we", 32'(fill_we), 32'd0);
      chk("rst_fill_data", 32'(fill_data), 32'd0);
      chk("rst_fill_idx", 32'(fill_word_idx), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wr_word_idx", 32'(wr_word_idx), 32'd0);
      if (r == 0) @(negedge clk);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("post_rst_no_accept", 32'(mem_enable), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Unaligned read fill: block 0x0040..0x004E.
    issue(1'b0, 16'h004B, 16'h0000, BW, a1);
    req_valid = 1'b0;
    wait_drain();

    // Block write to 0x0100, then direct memory check and readback.
    issue(1'b1, 16'h0100, 16'h5A00, BW, a1);
    req_valid = 1'b0;
    wait_drain();
    for (int k = 0; k < BW; k++) begin
      chk("wr_mem_content", 32'(mem_arr[16'h0080 + k]), 32'(16'h5A00 | 16'(k)));
    end
    issue(1'b0, 16'h010E, 16'h0000, BW, a1);
    req_valid = 1'b0;
    wait_drain();

    // Back-to-back with req_valid held: read then write.
    issue(1'b0, 16'h0100, 16'h0000, BW, a1);
    issue(1'b1, 16'h0386, 16'h7E10, BW, a2);
    req_valid = 1'b0;
    chk("b2b_accept_gap", 32'(a2 - a1), 32'(BW + 2));
    wait_drain();

    // Reset in beat 3 of a write to 0x0200: words 0..3 commit, no done.
    issue(1'b1, 16'h0200, 16'hC3C0, 4, a1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_enable", 32'(mem_enable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wr_word_idx", 32'(wr_word_idx), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(1'b0, 16'h0201, 16'h0000, BW, a1);
    req_valid = 1'b0;
    wait_drain();

    // Top of the address space.
    issue(1'b0, 16'hFFF7, 16'h0000, BW, a1);
    req_valid = 1'b0;
    wait_drain();

    // Random traffic, concentrated on a small region so reads see earlier writes.
    prev_acc = -100;
    chain    = 1'b0;
    for (int n = 0; n < 20; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 1) == 1) ? 16'h0300 + 16'($urandom_range(0, 63)) : 16'($urandom);
      issue(rw, ra, 16'($urandom), BW, a1);
      if (chain) chk("chain_accept_gap", 32'(a1 - prev_acc), 32'(BW + 2));
      prev_acc = a1;
      chain = ($urandom_range(0, 2) == 0);
      if (!chain) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    chk("done_count", 32'(done_seen), 32'(done_expected));
    chk("beats_left", 32'(exp_beat_q.size()), 32'd0);
    chk("fills_left", 32'(exp_fill_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_block_xfer.md
# mem_block_xfer

Block-transfer initiator for the single-cycle, byte-addressable, 16-bit word memory: the requester side of that memory's `addr`/`enable`/`wr`/`data_in`/`data_out` interface.

- A requester (cache fill/write-back logic) hands over one aligned block request.
- The block issues one memory word access per cycle, reading a block into the requester or writing a block out of it.
- It guarantees the memory never sees a concurrent read and write.

## Interface
- `ADDR_WIDTH`, default 16: byte address width, matching the memory's address width.
- `BLOCK_WORDS`, default 8: 16-bit words per block. Must be a power of two, at least 2. Block size in bytes is 2*BLOCK_WORDS.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  requester has a block request.
- `req_wr`  in  1  1 = block write to memory; 0 = block read (fill).
- `req_addr`  in  ADDR_WIDTH  any byte address inside the target block.
- `req_ready`  out  1  block can accept a request this cycle.
- `wr_word_idx`  out  clog2(BLOCK_WORDS)  index of the write word currently needed from the requester.
- `wr_word`  in  16  requester's write data for `wr_word_idx`; sampled in the same cycle.
- `fill_we`  out  1  `fill_data` is valid for `fill_word_idx` this cycle.
- `fill_word_idx`  out  clog2(BLOCK_WORDS)  index of the returned read word.
- `fill_data`  out  16  returned read word.
- `done`  out  1  one-cycle pulse when the transfer is complete.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`; bit 0 always 0.
- `mem_enable`  out  1  to memory `enable`.
- `mem_wr`  out  1  to memory `wr`.
- `mem_data_in`  out  16  to memory `data_in`.
- `mem_data_out`  in  16  from memory `data_out`; combinational read data.

## Operation
- **States:** IDLE, XFER, DONE (2-bit encoding). Beat counter `beat` is clog2(BLOCK_WORDS) bits wide.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: latch `req_wr` into `op_wr`, latch the base address, clear `beat`, go to XFER.
  - Base address = `req_addr` with the low clog2(BLOCK_WORDS)+1 bits cleared.
  - `req_*` are ignored after acceptance.
- **XFER** (`req_ready`=0)
  - `mem_enable`=1.
  - `mem_addr` = base | (`beat`<<1). This is an OR, not an add, so no carry into upper bits and no wrap.
  - `mem_wr`=`op_wr`.
  - `wr_word_idx`=`beat` during XFER; 0 otherwise.
  - Write op:
    - `mem_data_in`=`wr_word` (combinational pass-through).
    - The memory performs the write at the end-of-cycle edge.
  - Read op:
    - `mem_data_in`=0.
    - At the edge, register `mem_data_out` into `fill_data` and `beat` into `fill_word_idx`, and set `fill_we`=1 for the next cycle.
  - `beat` increments each cycle.
  - When `beat`==BLOCK_WORDS-1, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, `req_ready`=0, `mem_enable`=0.
  - Next state is IDLE unconditionally.
- Memory outputs outside XFER: `mem_enable`=0, `mem_wr`=0, `mem_addr`=0, `mem_data_in`=0.
- `mem_wr`=1 is only ever driven together with `mem_enable`=1. No read beat is ever issued during a write op.
- `fill_we`:
  - Registered; high for exactly BLOCK_WORDS consecutive cycles per read op.
  - Never high for a write op.
  - `fill_data` and `fill_word_idx` hold their last value when `fill_we`=0.
- **Reset:**
  - `rst_n`=0 at an edge forces IDLE, `beat`=0, `op_wr`=0, base=0, `fill_we`=0, `fill_data`=0, `fill_word_idx`=0.
  - Reset takes priority over every transition, including mid-XFER and DONE.
  - An aborted transfer produces no further memory beats and no `done` pulse.
  - Words already written stay written.
  - Outputs during and after reset:
    - `req_ready` is decoded from state, so it is 1 from the first cycle after the reset edge.
    - `done`, `mem_enable` and `mem_wr` are 0 from that cycle.
    - `wr_word_idx` is 0.

## Timing
- Cycle 0 = accept cycle.
- Beats k=0..BLOCK_WORDS-1 occur in cycles 1..BLOCK_WORDS.
- Read op: `fill_we` for word k is in cycle k+2.
- `done` is in cycle BLOCK_WORDS+1.
  - For a read op, this coincides with the last `fill_we`.
  - For a write op, the last write has already committed at the end of cycle BLOCK_WORDS.
- Earliest next accept is cycle BLOCK_WORDS+2 (cycle 10 for the default). Throughput is one block per BLOCK_WORDS+2 cycles.
- A `req_valid` held through XFER/DONE is accepted in the first IDLE cycle. Nothing is dropped, nothing is double-accepted.
- The `wr_word` to `mem_data_in` path is combinational. The requester must drive `wr_word` from `wr_word_idx` within the same cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req_valid`=1 → no accept, `mem_enable`=0, `fill_we`=0, `done`=0; after release, `req_ready`=1.
- **Read fill, unaligned:**
  - Stimulus: memory preloaded word[0x48+2k]=0xA000+k; read req at `req_addr`=0x004B.
  - `mem_addr` = 0x0040,0x0042,…,0x004E in cycles 1–8, `mem_wr`=0.
  - Words come back in order; a correct bench checks the `fill_data`/`fill_word_idx` pairs against the preloaded words at those addresses.
  - `done` in cycle 9.
- **Block write:**
  - Stimulus: `req_wr`=1, `req_addr`=0x0100, `wr_word`=0x5A00|`wr_word_idx`.
  - Memory holds 0x5A00..0x5A07 at 0x0100..0x010E afterwards.
  - `fill_we` never asserted.
  - Readback via a second (read) request matches.
- **Back-to-back:** `req_valid` held high for a read then a write → second accept exactly in cycle 10, exactly one `done` per request.
- **Reset mid-transfer:**
  - Stimulus: `rst_n`=0 at beat 3 of a write to 0x0200.
  - Only words 0–2 (or 0–3 if the beat-3 edge completed before reset) are changed.
  - No `done`; `req_ready`=1 the cycle after the reset edge.
- **Top of address space:** read req at 0xFFF7 → beats 0xFFF0..0xFFFE, no wrap to 0x0000.
